cir_result_buffer: RTL and testbench

- Downstream consumer of the registered adder stage: captures each WIDTH-bit sum presented with a valid strobe.
- Holds sums in a DEPTH-entry first-word-fall-through FIFO, drained by a valid/ready sink.
- The adder has no backpressure, so samples arriving while the FIFO is full are dropped and flagged.
- Keeps a running accumulator and sample count of accepted sums for bench self-checking and debug.

---
 rtl/cir_result_buffer.sv | 100 ++++++++++
 tb/tb_cir_result_buffer.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/cir_result_buffer.sv
// rtl/cir_result_buffer.sv - FWFT result FIFO behind the adder stage with drop flagging and running stats
module cir_result_buffer #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    parameter int ACC_W = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    input  logic [WIDTH-1:0]         in_data,
    output logic                     out_valid,
    output logic [WIDTH-1:0]         out_data,
    input  logic                     out_ready,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     full,
    output logic                     empty,
    output logic                     overflow,
    input  logic                     clear_stats,
    output logic [ACC_W-1:0]         acc_sum,
    output logic [15:0]              sample_cnt
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [LW-1:0]    r_level;
    logic             r_overflow;
    logic [ACC_W-1:0] r_acc;
    logic [15:0]      r_cnt;

    logic w_full;
    logic w_empty;
    logic w_pop;
    logic w_push;
    logic w_drop;
    logic [ACC_W-1:0] w_in_ext;

    assign w_full   = (r_level == LW'(DEPTH));
    assign w_empty  = (r_level == '0);
    assign w_pop    = !w_empty && out_ready;
    // The adder cannot stall, so a full FIFO only takes a sample if the head leaves this cycle.
    assign w_push   = in_valid && (!w_full || w_pop);
    assign w_drop   = in_valid && w_full && !w_pop;
    assign w_in_ext = ACC_W'(in_data);

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_level    <= '0;
            r_overflow <= 1'b0;
            r_acc      <= '0;
            r_cnt      <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= in_data;
                r_wr_ptr        <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + LW'(1);
                2'b01:   r_level <= r_level - LW'(1);
                default: r_level <= r_level;
            endcase

            // A clear in the same cycle as a new event keeps that event.
            if (clear_stats) begin
                r_acc      <= w_push ? w_in_ext : '0;
                r_cnt      <= w_push ? 16'd1 : 16'd0;
                r_overflow <= w_drop;
            end else begin
                if (w_push) begin
                    r_acc <= r_acc + w_in_ext;
                    r_cnt <= r_cnt + 16'd1;
                end
                if (w_drop) begin
                    r_overflow <= 1'b1;
                end
            end
        end
    end

    assign out_valid  = !w_empty;
    assign out_data   = r_mem[r_rd_ptr];
    assign level      = r_level;
    assign full       = w_full;
    assign empty      = w_empty;
    assign overflow   = r_overflow;
    assign acc_sum    = r_acc;
    assign sample_cnt = r_cnt;

endmodule

// File: tb/tb_cir_result_buffer.sv
// tb/tb_cir_result_buffer.sv - directed table-driven bench for cir_result_buffer
module tb_cir_result_buffer;

    localparam int WIDTH = 4;
    localparam int DEPTH = 4;
    localparam int ACC_W = 16;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic [WIDTH-1:0] in_data;
    logic             out_valid;
    logic [WIDTH-1:0] out_data;
    logic             out_ready;
    logic [2:0]       level;
    logic             full;
    logic             empty;
    logic             overflow;
    logic             clear_stats;
    logic [ACC_W-1:0] acc_sum;
    logic [15:0]      sample_cnt;

    int tests_run = 0;
    int tests_failed = 0;

    cir_result_buffer #(.WIDTH(WIDTH), .DEPTH(DEPTH), .ACC_W(ACC_W)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_data     (in_data),
        .out_valid   (out_valid),
        .out_data    (out_data),
        .out_ready   (out_ready),
        .level       (level),
        .full        (full),
        .empty       (empty),
        .overflow    (overflow),
        .clear_stats (clear_stats),
        .acc_sum     (acc_sum),
        .sample_cnt  (sample_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic       iv;
        logic [3:0] d;
        logic       rdy;
        logic       cs;
        logic       od_care;
        logic [3:0] od;
        logic [2:0] lvl;
        logic       ovf;
        int         acc;
        int         cnt;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input logic r, input logic iv, input int d, input logic rdy,
                                input logic cs, input logic care, input int od, input int lvl,
                                input logic ovf, input int acc, input int cnt);
        vec_t v;
        v.rst = r; v.iv = iv; v.d = 4'(d); v.rdy = rdy; v.cs = cs;
        v.od_care = care; v.od = 4'(od); v.lvl = 3'(lvl); v.ovf = ovf;
        v.acc = acc; v.cnt = cnt;
        vecs.push_back(v);
    endfunction

    task automatic chk(input string name, input int idx, input int act, input int exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s step %0d: got %0d expected %0d", name, idx, act, exp);
        end
    endtask

    task automatic check_state(input int idx, input logic care, input int od, input int lvl,
                               input logic ovf, input int acc, input int cnt);
        chk("level", idx, int'(level), lvl);
        chk("empty", idx, int'(empty), int'(lvl == 0));
        chk("full", idx, int'(full), int'(lvl == DEPTH));
        chk("out_valid", idx, int'(out_valid), int'(lvl != 0));
        if (care) chk("out_data", idx, int'(out_data), od);
        chk("overflow", idx, int'(overflow), int'(ovf));
        chk("acc_sum", idx, int'(acc_sum), acc);
        chk("sample_cnt", idx, int'(sample_cnt), cnt);
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0; clear_stats = 1'b0;

        //  rst iv  d rdy cs care od lvl ovf acc cnt
        add(1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
        add(1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
        add(0, 1, 1, 0, 0, 1, 1, 1, 0, 1, 1);
        add(0, 1, 3, 0, 0, 1, 1, 2, 0, 4, 2);
        add(0, 1, 5, 0, 0, 1, 1, 3, 0, 9, 3);
        add(0, 1, 7, 0, 0, 1, 1, 4, 0, 16, 4);
        add(0, 1, 9, 0, 0, 1, 1, 4, 1, 16, 4);
        add(0, 0, 0, 1, 0, 1, 3, 3, 1, 16, 4);
        add(0, 0, 0, 1, 0, 1, 5, 2, 1, 16, 4);
        add(0, 0, 0, 1, 0, 1, 7, 1, 1, 16, 4);
        add(0, 0, 0, 1, 0, 0, 0, 0, 1, 16, 4);
        add(0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0);
        add(0, 1, 1, 0, 0, 1, 1, 1, 0, 1, 1);
        add(0, 1, 3, 0, 0, 1, 1, 2, 0, 4, 2);
        add(0, 1, 5, 0, 0, 1, 1, 3, 0, 9, 3);
        add(0, 1, 7, 0, 0, 1, 1, 4, 0, 16, 4);
        add(0, 1, 9, 1, 0, 1, 3, 4, 0, 25, 5);
        add(0, 0, 0, 1, 0, 1, 5, 3, 0, 25, 5);
        add(0, 0, 0, 1, 0, 1, 7, 2, 0, 25, 5);
        add(0, 0, 0, 1, 0, 1, 9, 1, 0, 25, 5);
        add(0, 0, 0, 1, 0, 0, 0, 0, 0, 25, 5);
        add(0, 1, 2, 1, 0, 1, 2, 1, 0, 27, 6);
        add(0, 0, 0, 0, 0, 1, 2, 1, 0, 27, 6);
        add(0, 1, 6, 0, 1, 1, 2, 2, 0, 6, 1);
        add(0, 1, 4, 0, 0, 1, 2, 3, 0, 10, 2);
        add(1, 1, 8, 1, 0, 1, 0, 0, 0, 0, 0);
        add(0, 1, 1, 0, 0, 1, 1, 1, 0, 1, 1);
        add(0, 1, 2, 0, 0, 1, 1, 2, 0, 3, 2);
        add(0, 1, 3, 0, 0, 1, 1, 3, 0, 6, 3);
        add(0, 1, 4, 0, 0, 1, 1, 4, 0, 10, 4);
        add(0, 1, 5, 0, 1, 1, 1, 4, 1, 0, 0);
        add(1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0);

        foreach (vecs[i]) begin
            rst = vecs[i].rst; in_valid = vecs[i].iv; in_data = vecs[i].d;
            out_ready = vecs[i].rdy; clear_stats = vecs[i].cs;
            @(posedge clk); #1;
            check_state(i, vecs[i].od_care, int'(vecs[i].od), int'(vecs[i].lvl),
                        vecs[i].ovf, vecs[i].acc, vecs[i].cnt);
        end

        // Streaming: one-cycle latency, no bubbles, pointers wrap four times.
        rst = 1'b0; clear_stats = 1'b0; out_ready = 1'b1;
        for (int k = 0; k < 16; k++) begin
            in_valid = 1'b1; in_data = 4'(k);
            @(posedge clk); #1;
            chk("stream_data", 100 + k, int'(out_data), k);
            chk("stream_level", 100 + k, int'(level), 1);
        end
        in_valid = 1'b0;
        @(posedge clk); #1;
        check_state(200, 1'b0, 0, 0, 1'b0, 120, 16);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
